// File: rtl/config_pkg.sv
// Shared types and defaults for the fabric configuration loader.
// The fabric top-level reuses the default chain geometry from here.
package config_pkg;

  localparam int unsigned DEF_CHAIN_LEN = 16;
  localparam int unsigned DEF_WORD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } cfg_state_e;

  // Number of bitstream words needed to cover the whole chain.
  function automatic int unsigned words_needed(input int unsigned chain_len,
                                               input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/config_serializer.sv
// Parallel-in / serial-out word register; MSB leaves first.
// Clear has priority so the serial output idles at 0 outside of shifting.
module config_serializer
  import config_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              config_clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data_in,
  output logic              msb
);

  logic [WORD_W-1:0] sreg_q;
  logic [WORD_W-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (clear) begin
      sreg_d = '0;
    end else if (load) begin
      sreg_d = data_in;
    end else if (shift) begin
      sreg_d = sreg_q << 1;
    end
  end

  always_ff @(posedge config_clk) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign msb = sreg_q[WORD_W-1];

endmodule

// File: rtl/config_loader.sv
// Loads the fabric config chain from a word stream, MSB-first, then pulses done.
// state      | meaning
// IDLE       | waiting for start, all outputs low
// WAIT_WORD  | word_ready high, chain held (chain_en low)
// SHIFT      | one bit per cycle onto the chain
// DONE       | one-cycle done pulse
module config_loader
  import config_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned WORD_W    = DEF_WORD_W
) (
  input  logic              config_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              chain_data,
  output logic              chain_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TOT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BIT_W = $clog2(WORD_W + 1);

  cfg_state_e state_q, state_d;
  logic [TOT_W-1:0] tot_cnt_q, tot_cnt_d, tot_inc;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d, bit_inc;
  logic chain_en_q, chain_en_d;
  logic done_q, done_d;
  logic ser_clear, ser_load, ser_shift;

  assign tot_inc = tot_cnt_q + TOT_W'(1);
  assign bit_inc = bit_cnt_q + BIT_W'(1);

  always_comb begin
    state_d   = state_q;
    tot_cnt_d = tot_cnt_q;
    bit_cnt_d = bit_cnt_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WAIT_WORD;
          tot_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      ST_WAIT_WORD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (word_valid) begin
          ser_load  = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          ser_shift = 1'b1;
          tot_cnt_d = tot_inc;
          bit_cnt_d = bit_inc;
          // Chain full wins over word exhaustion: leftover low bits are dropped.
          if (tot_inc == TOT_W'(CHAIN_LEN)) begin
            state_d = ST_DONE;
          end else if (bit_inc == BIT_W'(WORD_W)) begin
            state_d = ST_WAIT_WORD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Serializer is emptied whenever the next cycle is not a shift cycle,
  // so chain_data is a clean flop output that reads 0 outside SHIFT.
  assign ser_clear  = (state_d != ST_SHIFT);
  assign chain_en_d = (state_d == ST_SHIFT);
  assign done_d     = (state_d == ST_DONE);

  always_ff @(posedge config_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tot_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      chain_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tot_cnt_q  <= tot_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      chain_en_q <= chain_en_d;
      done_q     <= done_d;
    end
  end

  config_serializer #(
    .WORD_W(WORD_W)
  ) u_serializer (
    .config_clk(config_clk),
    .rst       (rst),
    .clear     (ser_clear),
    .load      (ser_load),
    .shift     (ser_shift),
    .data_in   (word_in),
    .msb       (chain_data)
  );

  assign chain_en   = chain_en_q;
  assign done       = done_q;
  assign word_ready = (state_q == ST_WAIT_WORD);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 16-bit chain and a 10-bit chain share stimulus.
module tb_config_loader;

  logic       config_clk = 1'b0;
  logic       rst, start, abort, word_valid;
  logic [7:0] word_in;

  logic ready16, data16, en16, busy16, done16;
  logic ready10, data10, en10, busy10, done10;

  int checks = 0;
  int errors = 0;

  always #5 config_clk = ~config_clk;

  config_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .config_clk(config_clk), .rst(rst), .start(start), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(ready16),
    .chain_data(data16), .chain_en(en16), .busy(busy16), .done(done16)
  );

  config_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
    .config_clk(config_clk), .rst(rst), .start(start), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(ready10),
    .chain_data(data10), .chain_en(en10), .busy(busy10), .done(done10)
  );

  function automatic logic o_ready(input bit sel10); return sel10 ? ready10 : ready16; endfunction
  function automatic logic o_data(input bit sel10);  return sel10 ? data10  : data16;  endfunction
  function automatic logic o_en(input bit sel10);    return sel10 ? en10    : en16;    endfunction
  function automatic logic o_done(input bit sel10);  return sel10 ? done10  : done16;  endfunction

  task automatic tick();
    @(posedge config_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one load; ref_chain models the downstream chain shifting chain_data on chain_en.
  // done_at counts edges with the start-sampling edge as 1.
  task automatic run_load(input bit sel10, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int stall, input int start_at,
                          output logic [31:0] ref_chain, output int nbits,
                          output int done_at, output int ndone);
    logic [7:0] words [3];
    int widx;
    int stalled;
    words[0] = w0; words[1] = w1; words[2] = w2;
    ref_chain = '0; nbits = 0; done_at = -1; ndone = 0; widx = 0; stalled = 0;
    start = 1'b1; word_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      start   = (cyc == start_at);
      word_in = words[(widx > 2) ? 2 : widx];
      if (widx == 1 && stalled < stall && o_ready(sel10)) begin
        word_valid = 1'b0;
        stalled++;
      end else begin
        word_valid = (widx < 3);
      end
      if (word_valid && o_ready(sel10)) widx++;
      tick();
      if (o_en(sel10)) begin
        ref_chain = {ref_chain[30:0], o_data(sel10)};
        nbits++;
      end
      if (o_done(sel10)) begin
        ndone++;
        if (done_at < 0) done_at = cyc + 1;
      end
    end
    word_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ready16 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready16); end
    checks++; if (data16 !== 1'b0) begin errors++; $display("FAIL reset_data: got %b expected 0", data16); end
    checks++; if (en16 !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy16); end
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done16); end
  endtask

  task automatic test_start_wait_abort();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy16); end
    checks++; if (ready16 !== 1'b1) begin errors++; $display("FAIL start_ready: got %b expected 1", ready16); end
    tick();
    checks++; if (en16 !== 1'b0) begin errors++; $display("FAIL wait_en: got %b expected 0", en16); end
    checks++; if (ready16 !== 1'b1) begin errors++; $display("FAIL wait_ready_hold: got %b expected 1", ready16); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL wait_abort_busy: got %b expected 0", busy16); end
    checks++; if (ready16 !== 1'b0) begin errors++; $display("FAIL wait_abort_ready: got %b expected 0", ready16); end
  endtask

  task automatic test_basic();
    logic [31:0] rc; int nb, da, nd;
    do_reset();
    run_load(1'b0, 8'hA5, 8'h3C, 8'hFF, 0, 0, rc, nb, da, nd);
    checks++; if (rc[15:0] !== 16'hA53C) begin errors++; $display("FAIL basic_bits: got %h expected a53c", rc[15:0]); end
    checks++; if (nb !== 16) begin errors++; $display("FAIL basic_nbits: got %0d expected 16", nb); end
    checks++; if (da !== 19) begin errors++; $display("FAIL basic_done_at: got %0d expected 19", da); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_partial_word();
    logic [31:0] rc; int nb, da, nd;
    do_reset();
    run_load(1'b1, 8'hFF, 8'hC0, 8'h00, 0, 0, rc, nb, da, nd);
    checks++; if (rc[9:0] !== 10'h3FF) begin errors++; $display("FAIL partial_ones_bits: got %h expected 3ff", rc[9:0]); end
    checks++; if (nb !== 10) begin errors++; $display("FAIL partial_ones_nbits: got %0d expected 10", nb); end
    checks++; if (da !== 13) begin errors++; $display("FAIL partial_ones_done_at: got %0d expected 13", da); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL partial_ones_done_count: got %0d expected 1", nd); end
    do_reset();
    run_load(1'b1, 8'hB2, 8'h40, 8'hFF, 0, 0, rc, nb, da, nd);
    checks++; if (rc[9:0] !== 10'h2C9) begin errors++; $display("FAIL partial_mix_bits: got %h expected 2c9", rc[9:0]); end
    checks++; if (nb !== 10) begin errors++; $display("FAIL partial_mix_nbits: got %0d expected 10", nb); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rc; int nb, da, nd;
    do_reset();
    run_load(1'b0, 8'hA5, 8'h3C, 8'hFF, 5, 0, rc, nb, da, nd);
    checks++; if (rc[15:0] !== 16'hA53C) begin errors++; $display("FAIL bp_bits: got %h expected a53c", rc[15:0]); end
    checks++; if (nb !== 16) begin errors++; $display("FAIL bp_nbits: got %0d expected 16", nb); end
    checks++; if (da !== 24) begin errors++; $display("FAIL bp_done_at: got %0d expected 24", da); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_abort_shift();
    logic [2:0] got; int n; int seen_done; int seen_en;
    do_reset();
    got = '0; n = 0; seen_done = 0; seen_en = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    word_in = 8'hA5; word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      word_valid = 1'b0;
      if (en16) begin got = {got[1:0], data16}; n++; end
    end
    checks++; if (got !== 3'b101 || n !== 3) begin errors++; $display("FAIL abort_prefix: got %b/%0d expected 101/3", got, n); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (en16 !== 1'b0) begin errors++; $display("FAIL abort_en: got %b expected 0", en16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy16); end
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done16); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done16) seen_done++;
      if (en16) seen_en++;
    end
    checks++; if (seen_done !== 0 || seen_en !== 0) begin errors++; $display("FAIL abort_quiet: got done %0d en %0d expected 0 0", seen_done, seen_en); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL abort_restart: got %b expected 1", busy16); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] rc; int nb, da, nd;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    word_in = 8'hFF; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (en16 !== 1'b0) begin errors++; $display("FAIL rstmid_en: got %b expected 0", en16); end
    checks++; if (data16 !== 1'b0) begin errors++; $display("FAIL rstmid_data: got %b expected 0", data16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy16); end
    checks++; if (ready16 !== 1'b0 || done16 !== 1'b0) begin errors++; $display("FAIL rstmid_ready_done: got %b%b expected 00", ready16, done16); end
    run_load(1'b0, 8'h5A, 8'hC3, 8'hFF, 0, 0, rc, nb, da, nd);
    checks++; if (rc[15:0] !== 16'h5AC3) begin errors++; $display("FAIL rstmid_reload_bits: got %h expected 5ac3", rc[15:0]); end
    checks++; if (da !== 19 || nd !== 1) begin errors++; $display("FAIL rstmid_reload_done: got at %0d count %0d expected 19 1", da, nd); end
  endtask

  task automatic test_start_during_shift();
    logic [31:0] rc; int nb, da, nd;
    do_reset();
    run_load(1'b0, 8'h81, 8'h7E, 8'hFF, 0, 5, rc, nb, da, nd);
    checks++; if (rc[15:0] !== 16'h817E) begin errors++; $display("FAIL midstart_chain: got %h expected 817e", rc[15:0]); end
    checks++; if (nb !== 16) begin errors++; $display("FAIL midstart_nbits: got %0d expected 16", nb); end
    checks++; if (da !== 19 || nd !== 1) begin errors++; $display("FAIL midstart_done: got at %0d count %0d expected 19 1", da, nd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rc; int nb, da, nd;
    do_reset();
    run_load(1'b0, 8'h00, 8'hFF, 8'hAA, 0, 0, rc, nb, da, nd);
    checks++; if (rc[15:0] !== 16'h00FF || da !== 19) begin errors++; $display("FAIL b2b_first: got %h at %0d expected 00ff at 19", rc[15:0], da); end
    run_load(1'b0, 8'hF0, 8'h0F, 8'hAA, 0, 0, rc, nb, da, nd);
    checks++; if (rc[15:0] !== 16'hF00F || da !== 19) begin errors++; $display("FAIL b2b_second: got %h at %0d expected f00f at 19", rc[15:0], da); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_in = 8'h00;
    test_reset();
    test_start_wait_abort();
    test_basic();
    test_partial_word();
    test_backpressure();
    test_abort_shift();
    test_reset_mid_shift();
    test_start_during_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
